// File: rtl/tb_ethernet_pkg.sv
// Shared constants, state/source enums and the AXI-Stream beat payload for the
// reply serializer.
package tb_ethernet_pkg;

    localparam int unsigned ARP_BYTES      = 54;
    localparam int unsigned HEAD_BYTES     = 42;
    localparam int unsigned HEAD_VEC_BYTES = 50;
    localparam int unsigned MAX_PAYLOAD    = 63;
    localparam int unsigned BUF_BYTES      = 105;
    localparam int unsigned BEAT_BYTES     = 8;

    localparam int unsigned ARP_W       = ARP_BYTES * 8;
    localparam int unsigned HEAD_W      = HEAD_VEC_BYTES * 8;
    localparam int unsigned HEAD_KEEP_W = HEAD_BYTES * 8;
    localparam int unsigned PAY_W       = MAX_PAYLOAD * 8;
    localparam int unsigned BUF_W       = BUF_BYTES * 8;
    localparam int unsigned DATA_W      = BEAT_BYTES * 8;
    localparam int unsigned LEN_W       = 7;
    localparam int unsigned PAY_SIZE_W  = 6;
    localparam int unsigned UDP_SIZE_W  = 16;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;
    typedef enum logic [1:0] {SRC_ARP, SRC_ICMP, SRC_UDP} src_e;

    typedef struct packed {
        logic [DATA_W-1:0]     tdata;
        logic [BEAT_BYTES-1:0] tkeep;
        logic                  tlast;
    } axis_beat_t;

    // Next beat from the MSB end of the shift buffer; bytes past rem are zeroed.
    function automatic axis_beat_t make_beat(input logic [BUF_W-1:0] frame_i,
                                             input logic [LEN_W-1:0] rem_i);
        axis_beat_t b;
        b = '0;
        for (int n = 0; n < int'(BEAT_BYTES); n++) begin
            if (LEN_W'(n) < rem_i) begin
                b.tdata[8*n +: 8] = frame_i[BUF_W-1-8*n -: 8];
                b.tkeep[n]        = 1'b1;
            end
        end
        b.tlast = (rem_i <= LEN_W'(BEAT_BYTES));
        return b;
    endfunction

endpackage

// File: rtl/tb_ethernet_reply_arbiter.sv
// Pending-request flags, fixed-priority grant (ARP > ICMP > UDP) and a
// saturating counter of requests overwritten while still pending.
module tb_ethernet_reply_arbiter
    import tb_ethernet_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arp_pulse_i,
    input  logic             icmp_pulse_i,
    input  logic             udp_pulse_i,
    input  logic             grant_en_i,
    output logic             grant_valid_c,
    output src_e             grant_src_c,
    output logic [CNT_W-1:0] drop_cnt_o
);

    logic [2:0]       pend_q;
    logic [2:0]       pend_d;
    logic [2:0]       pulse_c;
    logic [2:0]       req_c;
    logic [2:0]       grant_oh_c;
    logic [2:0]       drop_c;
    logic [1:0]       drop_num_c;
    logic [CNT_W:0]   cnt_sum_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bit 0 = ARP, bit 1 = ICMP, bit 2 = UDP; a pulse in IDLE is grantable at once.
    assign pulse_c = {udp_pulse_i, icmp_pulse_i, arp_pulse_i};
    assign req_c   = pend_q | pulse_c;
    assign drop_c  = pend_q & pulse_c;

    always_comb begin
        grant_oh_c    = '0;
        grant_valid_c = 1'b0;
        grant_src_c   = SRC_ARP;
        if (grant_en_i) begin
            if (req_c[0]) begin
                grant_oh_c    = 3'b001;
                grant_valid_c = 1'b1;
                grant_src_c   = SRC_ARP;
            end else if (req_c[1]) begin
                grant_oh_c    = 3'b010;
                grant_valid_c = 1'b1;
                grant_src_c   = SRC_ICMP;
            end else if (req_c[2]) begin
                grant_oh_c    = 3'b100;
                grant_valid_c = 1'b1;
                grant_src_c   = SRC_UDP;
            end
        end
    end

    assign pend_d     = req_c & ~grant_oh_c;
    assign drop_num_c = {1'b0, drop_c[0]} + {1'b0, drop_c[1]} + {1'b0, drop_c[2]};
    assign cnt_sum_c  = {1'b0, cnt_q} + (CNT_W+1)'(drop_num_c);
    assign cnt_d      = cnt_sum_c[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_c[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign drop_cnt_o = cnt_q;

endmodule

// File: rtl/tb_ethernet_reply_serializer.sv
// Arbitrates ARP/ICMP/UDP reply frames and streams the granted frame as
// 64-bit AXI-Stream beats, byte 0 of each beat on tdata[7:0].
module tb_ethernet_reply_serializer
    import tb_ethernet_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ARP_W-1:0]      i_arp_reply,
    input  logic                  i_arp_reply_ready,
    input  logic [HEAD_W-1:0]     i_icmp_reply_head,
    input  logic [PAY_W-1:0]      i_icmp_reply_payload,
    input  logic [PAY_SIZE_W-1:0] i_icmp_payload_size,
    input  logic                  i_icmp_reply_ready,
    input  logic [HEAD_W-1:0]     i_udp_reply_head,
    input  logic [PAY_W-1:0]      i_udp_reply_payload,
    input  logic [UDP_SIZE_W-1:0] i_udp_payload_size,
    input  logic                  i_udp_reply_ready,
    output logic [DATA_W-1:0]     o_tdata,
    output logic [BEAT_BYTES-1:0] o_tkeep,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    input  logic                  i_tready,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_drop_cnt
);

    state_e                  state_q;
    src_e                    src_q;
    logic [BUF_W-1:0]        shift_q;
    logic [LEN_W-1:0]        rem_q;
    axis_beat_t              beat_q;
    logic                    valid_q;
    logic                    busy_q;

    logic                    grant_valid_c;
    src_e                    grant_src_c;
    logic [PAY_SIZE_W-1:0]   udp_size_c;
    logic [BUF_W-1:0]        load_buf_c;
    logic [LEN_W-1:0]        load_len_c;
    logic [BUF_W-1:0]        next_buf_c;
    logic [LEN_W-1:0]        next_rem_c;
    logic                    unused_head_c;

    tb_ethernet_reply_arbiter u_arbiter (
        .clk           (i_clk),
        .rst_n         (i_reset),
        .arp_pulse_i   (i_arp_reply_ready),
        .icmp_pulse_i  (i_icmp_reply_ready),
        .udp_pulse_i   (i_udp_reply_ready),
        .grant_en_i    (state_q == IDLE),
        .grant_valid_c (grant_valid_c),
        .grant_src_c   (grant_src_c),
        .drop_cnt_o    (o_drop_cnt)
    );

    // The low 8 bytes of each head vector are not part of the frame.
    assign unused_head_c = ^{i_icmp_reply_head[HEAD_W-HEAD_KEEP_W-1:0],
                             i_udp_reply_head[HEAD_W-HEAD_KEEP_W-1:0]};

    // Frame image and length sampled from the upstream vectors at LOAD.
    always_comb begin
        udp_size_c = (i_udp_payload_size > UDP_SIZE_W'(MAX_PAYLOAD))
                   ? PAY_SIZE_W'(MAX_PAYLOAD) : i_udp_payload_size[PAY_SIZE_W-1:0];
        load_buf_c = {i_arp_reply, {(BUF_W-ARP_W){1'b0}}};
        load_len_c = LEN_W'(ARP_BYTES);
        case (src_q)
            SRC_ICMP: begin
                load_buf_c = {i_icmp_reply_head[HEAD_W-1 -: HEAD_KEEP_W], i_icmp_reply_payload};
                load_len_c = LEN_W'(HEAD_BYTES) + LEN_W'(i_icmp_payload_size);
            end
            SRC_UDP: begin
                load_buf_c = {i_udp_reply_head[HEAD_W-1 -: HEAD_KEEP_W], i_udp_reply_payload};
                load_len_c = LEN_W'(HEAD_BYTES) + LEN_W'(udp_size_c);
            end
            default: begin
            end
        endcase
    end

    assign next_buf_c = shift_q << DATA_W;
    assign next_rem_c = rem_q - LEN_W'(BEAT_BYTES);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            src_q   <= SRC_ARP;
            shift_q <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid_c) begin
                        state_q <= LOAD;
                        src_q   <= grant_src_c;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_q <= load_buf_c;
                    rem_q   <= load_len_c;
                    beat_q  <= make_beat(load_buf_c, load_len_c);
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    // Beat registers only move on acceptance, so stalls hold them stable.
                    if (i_tready) begin
                        if (beat_q.tlast) begin
                            state_q <= IDLE;
                            beat_q  <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            shift_q <= next_buf_c;
                            rem_q   <= next_rem_c;
                            beat_q  <= make_beat(next_buf_c, next_rem_c);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tdata  = beat_q.tdata;
    assign o_tkeep  = beat_q.tkeep;
    assign o_tlast  = beat_q.tlast;
    assign o_tvalid = valid_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_tb_ethernet_reply_serializer.sv
// Scoreboard bench for the reply serializer: stimulus pushes expected beats and
// per-frame summaries, an independent monitor pops and compares accepted beats.
module tb_tb_ethernet_reply_serializer;
    import tb_ethernet_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [431:0] arp_v = '0;
    logic         arp_rdy = 1'b0;
    logic [399:0] icmp_head = '0;
    logic [503:0] icmp_pay = '0;
    logic [5:0]   icmp_size = '0;
    logic         icmp_rdy = 1'b0;
    logic [399:0] udp_head = '0;
    logic [503:0] udp_pay = '0;
    logic [15:0]  udp_size = '0;
    logic         udp_rdy = 1'b0;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic         tvalid;
    logic         tlast;
    logic         tready = 1'b1;
    logic         busy;
    logic [7:0]   drop_cnt;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } exp_beat_t;

    typedef struct {
        int          beats;
        logic [7:0]  lk;
    } meta_t;

    exp_beat_t exp_q[$];
    meta_t     meta_q[$];
    exp_beat_t cur_e;
    meta_t     cur_m;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int beat_in_frame = 0;
    int last_end_cyc = -1;
    bit gap_chk = 1'b0;
    bit mon_en = 1'b1;
    bit toggle_rdy = 1'b0;

    tb_ethernet_reply_serializer dut (
        .i_clk                (clk),
        .i_reset              (rst_n),
        .i_arp_reply          (arp_v),
        .i_arp_reply_ready    (arp_rdy),
        .i_icmp_reply_head    (icmp_head),
        .i_icmp_reply_payload (icmp_pay),
        .i_icmp_payload_size  (icmp_size),
        .i_icmp_reply_ready   (icmp_rdy),
        .i_udp_reply_head     (udp_head),
        .i_udp_reply_payload  (udp_pay),
        .i_udp_payload_size   (udp_size),
        .i_udp_reply_ready    (udp_rdy),
        .o_tdata              (tdata),
        .o_tkeep              (tkeep),
        .o_tvalid             (tvalid),
        .o_tlast              (tlast),
        .i_tready             (tready),
        .o_busy               (busy),
        .o_drop_cnt           (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    // Byte patterns of each source vector.
    function automatic logic [7:0] arp_b(input int i);  return 8'(i + 1);   endfunction
    function automatic logic [7:0] icmp_h(input int i); return 8'(64 + i);  endfunction
    function automatic logic [7:0] icmp_p(input int i); return 8'(128 + i); endfunction
    function automatic logic [7:0] udp_h(input int i);  return 8'(192 + i); endfunction
    function automatic logic [7:0] udp_p(input int i);  return 8'(16 + i);  endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // src 0 = ARP, 1 = ICMP, 2 = UDP; size is the effective payload byte count.
    task automatic push_frame(input int src, input int size, input int beats, input logic [7:0] lk);
        logic [7:0] bytes[$];
        exp_beat_t  e;
        meta_t      m;
        int         len;
        int         nb;
        if (src == 0) begin
            for (int i = 0; i < 54; i++) bytes.push_back(arp_b(i));
        end else begin
            for (int i = 0; i < 42; i++) bytes.push_back(src == 1 ? icmp_h(i) : udp_h(i));
            for (int j = 0; j < size; j++) bytes.push_back(src == 1 ? icmp_p(j) : udp_p(j));
        end
        len = bytes.size();
        nb  = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            e.d = '0;
            e.k = '0;
            e.l = (b == nb - 1);
            for (int n = 0; n < 8; n++) begin
                if (8 * b + n < len) begin
                    e.d[8*n +: 8] = bytes[8*b + n];
                    e.k[n]        = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        m.beats = beats;
        m.lk    = lk;
        meta_q.push_back(m);
    endtask

    task automatic pulse(input logic a, input logic i, input logic u);
        @(posedge clk); #1;
        arp_rdy = a; icmp_rdy = i; udp_rdy = u;
        @(posedge clk); #1;
        arp_rdy = 1'b0; icmp_rdy = 1'b0; udp_rdy = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL %s_timeout: %0d beats still pending, required 0", name, exp_q.size());
        end
    endtask

    // Ready driver: constant 1 or toggling 1010...
    initial forever begin
        @(posedge clk); #2;
        tready = toggle_rdy ? ~tready : 1'b1;
    end

    // Monitor: every valid cycle is checked against the head of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (mon_en && rst_n && tvalid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got tdata %h, required no beat", tdata);
            end else begin
                cur_e = exp_q[0];
                check("beat_data", tdata, cur_e.d);
                check("beat_keep", 64'(tkeep), 64'(cur_e.k));
                check("beat_last", 64'(tlast), 64'(cur_e.l));
                if (tready) begin
                    if (beat_in_frame == 0 && gap_chk && last_end_cyc >= 0)
                        check("frame_gap", 64'(cyc - last_end_cyc - 1), 64'd2);
                    void'(exp_q.pop_front());
                    beat_in_frame++;
                    if (tlast) begin
                        if (meta_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_frame_end: got tlast, required none");
                        end else begin
                            cur_m = meta_q.pop_front();
                            check("frame_beats", 64'(beat_in_frame), 64'(cur_m.beats));
                            check("frame_last_keep", 64'(tkeep), 64'(cur_m.lk));
                        end
                        beat_in_frame = 0;
                        last_end_cyc  = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        for (int i = 0; i < 54; i++) arp_v[431-8*i -: 8] = arp_b(i);
        for (int i = 0; i < 50; i++) begin
            icmp_head[399-8*i -: 8] = icmp_h(i);
            udp_head[399-8*i -: 8]  = udp_h(i);
        end
        for (int j = 0; j < 63; j++) begin
            icmp_pay[503-8*j -: 8] = icmp_p(j);
            udp_pay[503-8*j -: 8]  = udp_p(j);
        end

        // Reset values
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // ARP, tready = 1, with latency and MAC_DST check
        push_frame(0, 0, 7, 8'h3F);
        pulse(1'b1, 1'b0, 1'b0);
        check("arp_cycle1_tvalid", 64'(tvalid), 64'd0);
        @(posedge clk); #1;
        check("arp_cycle2_tvalid", 64'(tvalid), 64'd1);
        check("arp_mac_dst", 64'(tdata[47:0]), 64'h0000_0605_0403_0201);
        check("arp_busy", 64'(busy), 64'd1);
        wait_drain("arp");

        // ICMP size 32 with tready toggling
        toggle_rdy = 1'b1;
        icmp_size  = 6'd32;
        push_frame(1, 32, 10, 8'h03);
        pulse(1'b0, 1'b1, 1'b0);
        wait_drain("icmp32");
        toggle_rdy = 1'b0;
        repeat (3) @(posedge clk);

        // All three in the same cycle: ARP, ICMP, UDP order with 2-cycle gaps
        icmp_size    = 6'd5;
        udp_size     = 16'd1000;
        last_end_cyc = -1;
        gap_chk      = 1'b1;
        push_frame(0, 0, 7, 8'h3F);
        push_frame(1, 5, 6, 8'h7F);
        push_frame(2, 63, 14, 8'h01);
        pulse(1'b1, 1'b1, 1'b1);
        wait_drain("triple");
        gap_chk = 1'b0;
        check("triple_drop_cnt", 64'(drop_cnt), 64'd0);

        // UDP size 0
        udp_size = 16'd0;
        push_frame(2, 0, 6, 8'h03);
        pulse(1'b0, 1'b0, 1'b1);
        wait_drain("udp0");

        // Two ICMP pulses while ARP streams: one ICMP frame, one drop
        icmp_size = 6'd10;
        push_frame(0, 0, 7, 8'h3F);
        push_frame(1, 10, 7, 8'h0F);
        pulse(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_drain("overwrite");
        check("overwrite_drop_cnt", 64'(drop_cnt), 64'd1);

        // Reset on beat 3 of an ICMP frame
        mon_en    = 1'b0;
        icmp_size = 6'd32;
        pulse(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!tvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_first_valid", 64'(tvalid), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_beat3_data", tdata, 64'h5756_5554_5352_5150);
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid_async", 64'(tvalid), 64'd0);
        check("midrst_busy_async", 64'(busy), 64'd0);
        check("midrst_tlast_async", 64'(tlast), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tvalid) seen++;
        end
        check("midrst_no_beats_after", 64'(seen), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        mon_en = 1'b1;
        push_frame(2, 0, 6, 8'h03);
        pulse(1'b0, 1'b0, 1'b1);
        wait_drain("after_reset");

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("frames_empty", 64'(meta_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
